// File: rtl/xcvr_tx_reset_sequencer_pkg.sv
// Shared definitions for the bonded-TX reset sequencer.
//   xcvr_state_t      : 3-bit sequencer state, encodings 0..7 (debug-visible)
//   XCVR_T_*          : default timing constants in user-clock cycles
//   xcvr_max3()       : elaboration-time helper used to size the shared counter
package xcvr_pkg;

  typedef logic [2:0] xcvr_state_t;

  localparam xcvr_state_t S_RESET = 3'd0;
  localparam xcvr_state_t S_CAL   = 3'd1;
  localparam xcvr_state_t S_AHOLD = 3'd2;
  localparam xcvr_state_t S_AREL  = 3'd3;
  localparam xcvr_state_t S_LOCK  = 3'd4;
  localparam xcvr_state_t S_DHOLD = 3'd5;
  localparam xcvr_state_t S_DREL  = 3'd6;
  localparam xcvr_state_t S_READY = 3'd7;

  localparam int unsigned XCVR_T_ANALOG      = 70;
  localparam int unsigned XCVR_T_LOCK_FILTER = 1000;
  localparam int unsigned XCVR_T_DIGITAL     = 70;

  function automatic int unsigned xcvr_max3(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/xcvr_tx_reset_sequencer_sync.sv
// Two-flop synchronizer for a bus of independent asynchronous bits.
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset, clears both stages
//   d_i     : asynchronous input bits
//   q_o     : synchronized bits, two destination cycles of latency
module xcvr_sync_bit #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/xcvr_tx_reset_sequencer.sv
// Bonded-TX reset sequencer: holds analog/digital PHY reset through calibration,
// releases analog reset, waits for a filtered fPLL lock, releases digital reset and
// raises tx_ready. Re-sequences on restart, recalibration or lock loss.
//   clock                : free-running user clock
//   reset                : asynchronous active-low reset
//   restart              : one-cycle pulse, restarts the whole sequence
//   pll_locked           : fPLL lock (asynchronous)
//   tx_cal_busy          : per-lane calibration busy (asynchronous)
//   tx_analogreset_stat  : per-lane analog reset ack (asynchronous)
//   tx_digitalreset_stat : per-lane digital reset ack (asynchronous)
//   tx_analogreset       : per-lane analog reset, active-high, registered
//   tx_digitalreset      : per-lane digital reset, active-high, registered
//   tx_ready             : per-lane ready, all bits equal, registered
//   state                : current state encoding for debug
module xcvr_tx_reset_sequencer
  import xcvr_pkg::*;
#(
  parameter int unsigned LANES         = 4,
  parameter int unsigned T_ANALOG      = XCVR_T_ANALOG,
  parameter int unsigned T_LOCK_FILTER = XCVR_T_LOCK_FILTER,
  parameter int unsigned T_DIGITAL     = XCVR_T_DIGITAL
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             restart,
  input  logic             pll_locked,
  input  logic [LANES-1:0] tx_cal_busy,
  input  logic [LANES-1:0] tx_analogreset_stat,
  input  logic [LANES-1:0] tx_digitalreset_stat,
  output logic [LANES-1:0] tx_analogreset,
  output logic [LANES-1:0] tx_digitalreset,
  output logic [LANES-1:0] tx_ready,
  output logic [2:0]       state
);

  localparam int unsigned CNT_MAX = xcvr_max3(T_ANALOG, T_LOCK_FILTER, T_DIGITAL);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t A_LAST = cnt_t'(T_ANALOG - 1);
  localparam cnt_t L_LAST = cnt_t'(T_LOCK_FILTER - 1);
  localparam cnt_t D_LAST = cnt_t'(T_DIGITAL - 1);

  // Synchronized inputs
  logic             lock_s;
  logic [LANES-1:0] cal_s;
  logic [LANES-1:0] astat_s;
  logic [LANES-1:0] dstat_s;

  xcvr_sync_bit #(.WIDTH(1)) u_sync_lock (
    .clk_i (clock), .rst_ni (reset), .d_i (pll_locked), .q_o (lock_s)
  );
  xcvr_sync_bit #(.WIDTH(LANES)) u_sync_cal (
    .clk_i (clock), .rst_ni (reset), .d_i (tx_cal_busy), .q_o (cal_s)
  );
  xcvr_sync_bit #(.WIDTH(LANES)) u_sync_astat (
    .clk_i (clock), .rst_ni (reset), .d_i (tx_analogreset_stat), .q_o (astat_s)
  );
  xcvr_sync_bit #(.WIDTH(LANES)) u_sync_dstat (
    .clk_i (clock), .rst_ni (reset), .d_i (tx_digitalreset_stat), .q_o (dstat_s)
  );

  logic cal_busy;
  logic cal_prev_q;
  logic cal_rise;
  logic astat_all;
  logic astat_none;
  logic dstat_none;

  assign cal_busy   = |cal_s;
  assign cal_rise   = cal_busy & ~cal_prev_q;
  assign astat_all  = &astat_s;
  assign astat_none = ~|astat_s;
  assign dstat_none = ~|dstat_s;

  xcvr_state_t state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  cnt_t        cnt_inc;

  // Saturating increment: the counter never wraps back into a hold window.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + cnt_t'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;

    case (state_q)
      S_RESET: begin
        state_d = S_CAL;
        cnt_d   = '0;
      end
      S_CAL: begin
        cnt_d = '0;
        if (!cal_busy && astat_all) state_d = S_AHOLD;
      end
      S_AHOLD: begin
        if (cnt_q == A_LAST) state_d = S_AREL;
      end
      S_AREL: begin
        cnt_d = '0;
        if (astat_none) state_d = S_LOCK;
      end
      S_LOCK: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == L_LAST) begin
          state_d = S_DHOLD;
          cnt_d   = '0;
        end
      end
      S_DHOLD: begin
        if (cnt_q == D_LAST) state_d = S_DREL;
      end
      S_DREL: begin
        if (dstat_none) state_d = S_READY;
      end
      S_READY: begin
        state_d = S_READY;
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
      end
    endcase

    // Aborts override the per-state decision; restart beats lock loss.
    if (restart || cal_rise) begin
      state_d = S_RESET;
      cnt_d   = '0;
    end else if (!lock_s && (state_q == S_DHOLD || state_q == S_DREL ||
                             state_q == S_READY)) begin
      state_d = S_LOCK;
      cnt_d   = '0;
    end
  end

  // Outputs are decoded from the next state and registered, so they move on the
  // same edge as the state and never glitch.
  logic analog_d, digital_d, ready_d;

  assign analog_d  = (state_d == S_RESET) || (state_d == S_CAL) || (state_d == S_AHOLD);
  assign digital_d = (state_d != S_DREL) && (state_d != S_READY);
  assign ready_d   = (state_d == S_READY);

  logic [LANES-1:0] analog_q, digital_q, ready_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RESET;
      cnt_q      <= '0;
      cal_prev_q <= 1'b0;
      analog_q   <= '1;
      digital_q  <= '1;
      ready_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cal_prev_q <= cal_busy;
      analog_q   <= {LANES{analog_d}};
      digital_q  <= {LANES{digital_d}};
      ready_q    <= {LANES{ready_d}};
    end
  end

  assign tx_analogreset  = analog_q;
  assign tx_digitalreset = digital_q;
  assign tx_ready        = ready_q;
  assign state           = state_q;

endmodule
